// File: rtl/bitonic_stream_sort64_pkg.sv
// Shared word width and control-state encoding for the streaming bitonic sorter.
package bitonic_stream_sort64_pkg;

  localparam int WORD_W = 64;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/bitonic_sort64.sv
// Combinational bitonic sorting network over K unsigned 64-bit words; dir_i=1 puts the minimum in slot 0.
// Zero latency, no flow control: the output follows the inputs within the same cycle.
module bitonic_sort64
  import bitonic_stream_sort64_pkg::*;
#(
  parameter int K = 16
) (
  input  logic [K*WORD_W-1:0] data_i,
  input  logic                dir_i,
  output logic [K*WORD_W-1:0] data_o
);

  logic [WORD_W-1:0] v [K];
  logic [WORD_W-1:0] tmp;
  int                l;
  logic              up;

  always_comb begin
    tmp = '0;
    l   = 0;
    up  = 1'b0;
    for (int i = 0; i < K; i++) begin
      v[i] = data_i[i*WORD_W +: WORD_W];
    end
    // Stage k merges bitonic runs of length k; run direction alternates with bit k of the index.
    for (int k = 2; k <= K; k = k * 2) begin
      for (int j = k / 2; j > 0; j = j / 2) begin
        for (int i = 0; i < K; i++) begin
          l = i ^ j;
          if (l > i) begin
            up = (((i & k) == 0) == dir_i);
            if (up ? (v[i] > v[l]) : (v[i] < v[l])) begin
              tmp  = v[i];
              v[i] = v[l];
              v[l] = tmp;
            end
          end
        end
      end
    end
    data_o = '0;
    for (int i = 0; i < K; i++) begin
      data_o[i*WORD_W +: WORD_W] = v[i];
    end
  end

endmodule

// File: rtl/bitonic_stream_sort64.sv
// Block stream wrapper around bitonic_sort64: collect K words, sort in one cycle, replay K words.
// First output two cycles after the K-th accept; in_ready is low from SORT until the block is drained.
module bitonic_stream_sort64
  import bitonic_stream_sort64_pkg::*;
#(
  parameter int K = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_dir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last
);

  localparam int CW = $clog2(K);

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic                cnt_last;
  logic                dir_q;
  logic [K*WORD_W-1:0] arr_q;
  logic [K*WORD_W-1:0] res_q;
  logic [K*WORD_W-1:0] sorted;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [WORD_W-1:0]   out_data_q;
  logic                out_last_q;

  // K is a power of two, so the natural wrap of the counter matches the block boundary.
  assign cnt_d    = cnt_q + 1'b1;
  assign cnt_last = (cnt_q == CW'(K - 1));

  bitonic_sort64 #(.K(K)) u_sort (
    .data_i (arr_q),
    .dir_i  (dir_q),
    .data_o (sorted)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      dir_q       <= 1'b1;
      arr_q       <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            arr_q[int'(cnt_q)*WORD_W +: WORD_W] <= in_data;
            if (cnt_q == '0) begin
              dir_q <= in_dir;
            end
            cnt_q <= cnt_d;
            if (cnt_last) begin
              state_q    <= SORT;
              in_ready_q <= 1'b0;
            end
          end
        end
        SORT: begin
          res_q       <= sorted;
          out_valid_q <= 1'b1;
          out_data_q  <= sorted[WORD_W-1:0];
          out_last_q  <= 1'b0;
          state_q     <= DRAIN;
        end
        DRAIN: begin
          // Next beat is preloaded on each handshake so the output stays registered and stable under stall.
          if (out_ready) begin
            cnt_q <= cnt_d;
            if (cnt_last) begin
              state_q     <= FILL;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_last_q  <= 1'b0;
            end else begin
              out_data_q <= res_q[int'(cnt_d)*WORD_W +: WORD_W];
              out_last_q <= (cnt_d == CW'(K - 1));
            end
          end
        end
        default: begin
          state_q <= FILL;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_bitonic_stream_sort64.sv
// Directed and randomized checks of bitonic_stream_sort64 (K=4) against a sort-based reference model.
module tb_bitonic_stream_sort64;

  localparam int K = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_dir;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;

  int nvec;
  int nerr;

  logic [63:0] blk  [K];
  logic [63:0] expv [K];
  logic [63:0] words [2*K];
  logic [63:0] exp2 [2*K];

  bitonic_stream_sort64 #(.K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain selection sort ascending, reversed for descending.
  task automatic model(input logic dir);
    logic [63:0] a [K];
    logic [63:0] t;
    for (int i = 0; i < K; i++) a[i] = blk[i];
    for (int i = 0; i < K; i++)
      for (int j = i + 1; j < K; j++)
        if (a[j] < a[i]) begin t = a[i]; a[i] = a[j]; a[j] = t; end
    for (int i = 0; i < K; i++) expv[i] = dir ? a[i] : a[K-1-i];
  endtask

  task automatic push(input logic [63:0] d, input logic dr);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dr;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("push_timeout_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_block(input logic dir0, input logic dirrest, input int maxgap);
    for (int i = 0; i < K; i++) begin
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      push(blk[i], (i == 0) ? dir0 : dirrest);
    end
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic drain(input int mode);
    int beat;
    int cyc;
    logic rdy;
    logic [3:0] pat;
    pat  = 4'b1001;
    beat = 0;
    cyc  = 0;
    while (beat < K && cyc < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[3 - (cyc % 4)];
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      out_ready = rdy;
      if (out_valid === 1'b1) begin
        chk("drain_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("drain_data", out_data, expv[beat]);
        chk("drain_last", {63'd0, out_last}, {63'd0, beat == K - 1});
        if (rdy) beat++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (cyc >= 200) chk("drain_timeout_beats", beat, K);
    chk("post_drain_out_valid", {63'd0, out_valid}, 64'd0);
    chk("post_drain_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    nvec      = 0;
    nerr      = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dir    = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_last", {63'd0, out_last}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

    // Ascending, back-to-back, latency check.
    blk[0] = 7; blk[1] = 3; blk[2] = 9; blk[3] = 1;
    model(1'b1);
    out_ready = 1'b1;
    push_block(1'b1, 1'b1, 0);
    chk("lat_sort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("lat_sort_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    chk("lat_first_out_valid", {63'd0, out_valid}, 64'd1);
    drain(0);

    // Descending with duplicates and all-ones.
    blk[0] = 5; blk[1] = 5; blk[2] = 0; blk[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    model(1'b0);
    push_block(1'b0, 1'b0, 0);
    drain(0);

    // Stalled drain.
    blk[0] = 40; blk[1] = 10; blk[2] = 30; blk[3] = 20;
    model(1'b1);
    push_block(1'b1, 1'b1, 1);
    drain(1);

    // Direction flips after the first word are ignored.
    blk[0] = 12; blk[1] = 4; blk[2] = 8; blk[3] = 2;
    model(1'b1);
    push_block(1'b1, 1'b0, 0);
    drain(0);
    model(1'b0);
    push_block(1'b0, 1'b1, 0);
    drain(2);

    // Reset mid-fill.
    push(64'd50, 1'b0);
    push(64'd60, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midfill_rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("midfill_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midfill_rst_out_data", out_data, 64'd0);
    chk("midfill_rst_out_last", {63'd0, out_last}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midfill_rel_in_ready", {63'd0, in_ready}, 64'd1);
    blk[0] = 2; blk[1] = 1; blk[2] = 4; blk[3] = 3;
    model(1'b1);
    push_block(1'b1, 1'b1, 0);
    drain(0);

    // Reset mid-drain: no beat may follow.
    blk[0] = 9; blk[1] = 8; blk[2] = 7; blk[3] = 6;
    push_block(1'b1, 1'b1, 0);
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("middrain_pre_out_valid", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("middrain_no_beat", {63'd0, out_valid}, 64'd0);
    end
    out_ready = 1'b0;

    // Two blocks with in_valid held high: fixed 2K+1 cycle rhythm.
    for (int i = 0; i < 2 * K; i++) words[i] = 64'($urandom_range(0, 1000));
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < K; i++) blk[i] = words[b*K + i];
      model(b == 0);
      for (int i = 0; i < K; i++) exp2[b*K + i] = expv[i];
    end
    begin
      int idx;
      logic rdy_seen;
      idx = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int c = 0; c < 2 * (2*K + 1); c++) begin
        in_data  = words[(idx < 2*K) ? idx : 2*K - 1];
        in_dir   = (idx < K);
        rdy_seen = in_ready;
        chk("b2b_in_ready", {63'd0, in_ready}, {63'd0, (c % (2*K + 1)) < K});
        chk("b2b_out_valid", {63'd0, out_valid}, {63'd0, (c % (2*K + 1)) > K});
        if ((c % (2*K + 1)) > K) begin
          chk("b2b_data", out_data, exp2[(c / (2*K + 1))*K + (c % (2*K + 1)) - K - 1]);
          chk("b2b_last", {63'd0, out_last}, {63'd0, (c % (2*K + 1)) == 2*K});
        end
        @(negedge clk);
        if (rdy_seen === 1'b1) idx++;
      end
      in_valid = 1'b0;
      chk("b2b_accepts", idx, 2*K);
      chk("b2b_final_in_ready", {63'd0, in_ready}, 64'd1);
      out_ready = 1'b0;
    end

    // Randomized blocks.
    for (int b = 0; b < 12; b++) begin
      logic d;
      d = 1'($urandom_range(0, 1));
      for (int i = 0; i < K; i++)
        blk[i] = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      model(d);
      push_block(d, ~d, 2);
      drain(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
